// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: opcodes, ALU op encoding, writeback/jump codes
// and the control word produced by the decoder.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    localparam logic [1:0] IR_PC4 = 2'b00;
    localparam logic [1:0] IR_ALU = 2'b01;
    localparam logic [1:0] IR_MEM = 2'b10;

    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_JAL  = 2'b01;
    localparam logic [1:0] JMP_JALR = 2'b10;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic       we_reg;
        logic       adder_pc;
        logic [1:0] input_reg;
        logic       source_alu;
        logic [3:0] op_code_alu;
        logic       mem_we;
        logic [2:0] mem_size;
        logic [1:0] jmp_pc;
        logic       b_pc;
        logic       alu_not;
        logic       illegal;
    } ctrl_t;

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic logic [3:0] alu_op(input logic [2:0] funct3, input logic alt);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32I/RV64I decoder: raw instruction word to control word,
// register indices and extended immediate.
module decode_comb
    import riscv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int REG_W     = 5,
    parameter int X0_SQUASH = 1
) (
    input  logic [31:0]      instr,
    output ctrl_t            ctrl,
    output logic [XLEN-1:0]  immediate,
    output logic [REG_W-1:0] select_a,
    output logic [REG_W-1:0] select_b,
    output logic [REG_W-1:0] select_d
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, shamt, shamt_w;
    logic            is_shift;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    assign imm_i   = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s   = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b   = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j   = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u   = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
    assign shamt_w = {{(XLEN-5){1'b0}}, instr[24:20]};
    assign shamt   = (XLEN == 32) ? shamt_w : {{(XLEN-6){1'b0}}, instr[25:20]};

    always_comb begin
        ctrl      = '0;
        immediate = '0;
        select_a  = REG_W'(instr[19:15]);
        select_b  = REG_W'(instr[24:20]);
        select_d  = REG_W'(instr[11:7]);

        case (opcode)
            OPC_OP: begin
                ctrl.we_reg      = 1'b1;
                ctrl.input_reg   = IR_ALU;
                ctrl.op_code_alu = alu_op(funct3, instr[30]);
            end
            OPC_OP_32: begin
                ctrl.illegal     = (XLEN == 32);
                ctrl.we_reg      = 1'b1;
                ctrl.input_reg   = IR_ALU;
                ctrl.op_code_alu = alu_op(funct3, instr[30]);
            end
            OPC_OP_IMM, OPC_OP_IMM_32: begin
                ctrl.illegal     = (opcode == OPC_OP_IMM_32) && (XLEN == 32);
                ctrl.we_reg      = 1'b1;
                ctrl.input_reg   = IR_ALU;
                ctrl.source_alu  = 1'b1;
                // immediate forms never produce SUB; instr[30] only picks SRAI
                ctrl.op_code_alu = alu_op(funct3, (funct3 == 3'b101) && instr[30]);
                if (is_shift)
                    immediate = (opcode == OPC_OP_IMM) ? shamt : shamt_w;
                else
                    immediate = imm_i;
            end
            OPC_LOAD: begin
                ctrl.we_reg     = 1'b1;
                ctrl.input_reg  = IR_MEM;
                ctrl.source_alu = 1'b1;
                ctrl.mem_size   = funct3;
                immediate       = imm_i;
            end
            OPC_STORE: begin
                ctrl.mem_we     = 1'b1;
                ctrl.source_alu = 1'b1;
                ctrl.mem_size   = funct3;
                immediate       = imm_s;
            end
            OPC_BRANCH: begin
                ctrl.b_pc = 1'b1;
                immediate = imm_b;
                case (funct3)
                    3'b000:  begin ctrl.op_code_alu = ALU_SUB;  ctrl.alu_not = 1'b1; end
                    3'b001:  begin ctrl.op_code_alu = ALU_SUB;  ctrl.alu_not = 1'b0; end
                    3'b100:  begin ctrl.op_code_alu = ALU_SLT;  ctrl.alu_not = 1'b0; end
                    3'b101:  begin ctrl.op_code_alu = ALU_SLT;  ctrl.alu_not = 1'b1; end
                    3'b110:  begin ctrl.op_code_alu = ALU_SLTU; ctrl.alu_not = 1'b0; end
                    3'b111:  begin ctrl.op_code_alu = ALU_SLTU; ctrl.alu_not = 1'b1; end
                    default: ctrl.illegal = 1'b1;
                endcase
            end
            OPC_JAL: begin
                ctrl.we_reg    = 1'b1;
                ctrl.input_reg = IR_PC4;
                ctrl.jmp_pc    = JMP_JAL;
                immediate      = imm_j;
            end
            OPC_JALR: begin
                ctrl.we_reg     = 1'b1;
                ctrl.input_reg  = IR_PC4;
                ctrl.jmp_pc     = JMP_JALR;
                ctrl.source_alu = 1'b1;
                immediate       = imm_i;
            end
            OPC_LUI: begin
                ctrl.we_reg     = 1'b1;
                ctrl.input_reg  = IR_ALU;
                ctrl.source_alu = 1'b1;
                select_a        = '0;
                immediate       = imm_u;
            end
            OPC_AUIPC: begin
                ctrl.we_reg     = 1'b1;
                ctrl.adder_pc   = 1'b1;
                ctrl.input_reg  = IR_ALU;
                ctrl.source_alu = 1'b1;
                immediate       = imm_u;
            end
            default: ctrl.illegal = 1'b1;
        endcase

        // Illegal words and the canonical NOP travel as empty control words
        if (ctrl.illegal || (instr == INSTR_NOP)) begin
            ctrl         = '0;
            ctrl.illegal = (instr != INSTR_NOP);
            immediate    = '0;
            select_a     = '0;
            select_b     = '0;
            select_d     = '0;
        end

        if ((X0_SQUASH != 0) && (instr[11:7] == 5'd0))
            ctrl.we_reg = 1'b0;
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decode_comb behind a valid/ready handshake with a
// main register plus skid register (2-entry FIFO) and flush.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int REG_W     = 5,
    parameter int X0_SQUASH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_immediate,
    output logic             out_we_reg,
    output logic             out_adder_pc,
    output logic [1:0]       out_input_reg,
    output logic [REG_W-1:0] out_select_a,
    output logic [REG_W-1:0] out_select_b,
    output logic [REG_W-1:0] out_select_d,
    output logic             out_source_alu,
    output logic [3:0]       out_op_code_alu,
    output logic             out_mem_we,
    output logic [2:0]       out_mem_size,
    output logic [1:0]       out_jmp_pc,
    output logic             out_b_pc,
    output logic             out_alu_not,
    output logic             out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  imm;
        logic [REG_W-1:0] sel_a;
        logic [REG_W-1:0] sel_b;
        logic [REG_W-1:0] sel_d;
        ctrl_t            ctrl;
    } entry_t;

    ctrl_t            dec_ctrl;
    logic [XLEN-1:0]  dec_imm;
    logic [REG_W-1:0] dec_a, dec_b, dec_d;
    entry_t           new_p0, main_p1, skid_p1;
    logic             vld_p1, skid_vld_p1;
    logic             accept, main_free;

    decode_comb #(.XLEN(XLEN), .REG_W(REG_W), .X0_SQUASH(X0_SQUASH)) u_decode_comb (
        .instr     (in_instr),
        .ctrl      (dec_ctrl),
        .immediate (dec_imm),
        .select_a  (dec_a),
        .select_b  (dec_b),
        .select_d  (dec_d)
    );

    always_comb begin
        new_p0.pc    = in_pc;
        new_p0.imm   = dec_imm;
        new_p0.sel_a = dec_a;
        new_p0.sel_b = dec_b;
        new_p0.sel_d = dec_d;
        new_p0.ctrl  = dec_ctrl;
    end

    assign in_ready  = ~skid_vld_p1;
    assign accept    = in_valid & in_ready;
    assign main_free = ~vld_p1 | out_ready;

    // ---- stage boundary: main/skid registers ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            main_p1     <= '0;
        end else if (flush) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else if (main_free) begin
            if (skid_vld_p1) begin
                main_p1     <= skid_p1;
                vld_p1      <= 1'b1;
                skid_vld_p1 <= accept;
                if (accept) skid_p1 <= new_p0;
            end else begin
                vld_p1 <= accept;
                if (accept) main_p1 <= new_p0;
            end
        end else if (accept) begin
            skid_p1     <= new_p0;
            skid_vld_p1 <= 1'b1;
        end
    end

    assign out_valid       = vld_p1;
    assign out_pc          = main_p1.pc;
    assign out_immediate   = main_p1.imm;
    assign out_select_a    = main_p1.sel_a;
    assign out_select_b    = main_p1.sel_b;
    assign out_select_d    = main_p1.sel_d;
    assign out_we_reg      = main_p1.ctrl.we_reg;
    assign out_adder_pc    = main_p1.ctrl.adder_pc;
    assign out_input_reg   = main_p1.ctrl.input_reg;
    assign out_source_alu  = main_p1.ctrl.source_alu;
    assign out_op_code_alu = main_p1.ctrl.op_code_alu;
    assign out_mem_we      = main_p1.ctrl.mem_we;
    assign out_mem_size    = main_p1.ctrl.mem_size;
    assign out_jmp_pc      = main_p1.ctrl.jmp_pc;
    assign out_b_pc        = main_p1.ctrl.b_pc;
    assign out_alu_not     = main_p1.ctrl.alu_not;
    assign out_illegal     = main_p1.ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage (XLEN=32): directed handshake/decode steps followed by
// random traffic, all checked against an ISA-level decoder and a 2-deep FIFO model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1, flush = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_instr = 32'h0, in_pc = 32'h0;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] out_pc, out_immediate;
    logic        out_we_reg, out_adder_pc, out_source_alu, out_mem_we;
    logic [1:0]  out_input_reg, out_jmp_pc;
    logic [4:0]  out_select_a, out_select_b, out_select_d;
    logic [3:0]  out_op_code_alu;
    logic [2:0]  out_mem_size;
    logic        out_b_pc, out_alu_not, out_illegal;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .REG_W(5), .X0_SQUASH(1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_immediate(out_immediate), .out_we_reg(out_we_reg),
        .out_adder_pc(out_adder_pc), .out_input_reg(out_input_reg),
        .out_select_a(out_select_a), .out_select_b(out_select_b), .out_select_d(out_select_d),
        .out_source_alu(out_source_alu), .out_op_code_alu(out_op_code_alu),
        .out_mem_we(out_mem_we), .out_mem_size(out_mem_size), .out_jmp_pc(out_jmp_pc),
        .out_b_pc(out_b_pc), .out_alu_not(out_alu_not), .out_illegal(out_illegal)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic        we;
        logic        apc;
        logic [1:0]  ir;
        logic [4:0]  a, b, d;
        logic        src;
        logic [3:0]  op;
        logic        mwe;
        logic [2:0]  msz;
        logic [1:0]  jmp;
        logic        bpc;
        logic        anot;
        logic        ill;
    } exp_t;

    exp_t q[$];

    // ISA-level reference: ALU ops numbered ADD..AND = 0,2,3,4,5,6,8,9 by funct3,
    // with the "alternate" form (SUB/SRA) one above its base op.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        logic [3:0] alu_tab [8];
        logic [2:0] f3;
        bit legal;
        int v;
        alu_tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        e = '0;
        f3 = w[14:12];
        legal = 1;
        e.a = w[19:15]; e.b = w[24:20]; e.d = w[11:7];
        case (w[6:0])
            7'h33: begin e.we = 1; e.ir = 1; e.op = alu_tab[f3] + 4'(((f3 == 0) || (f3 == 5)) && w[30]); end
            7'h13: begin
                e.we = 1; e.ir = 1; e.src = 1;
                e.op = alu_tab[f3] + 4'((f3 == 5) && w[30]);
                if (f3 == 1 || f3 == 5) e.imm = 32'(w[24:20]);
                else begin v = $signed(w[31:20]); e.imm = v; end
            end
            7'h03: begin e.we = 1; e.ir = 2; e.src = 1; e.msz = f3; v = $signed(w[31:20]); e.imm = v; end
            7'h23: begin e.mwe = 1; e.src = 1; e.msz = f3; v = $signed({w[31:25], w[11:7]}); e.imm = v; end
            7'h63: begin
                if (f3 == 2 || f3 == 3) legal = 0;
                e.bpc = 1;
                e.op = (f3 < 4) ? 4'd1 : ((f3 < 6) ? 4'd3 : 4'd4);
                e.anot = (f3 < 4) ? !f3[0] : f3[0];
                v = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0}); e.imm = v;
            end
            7'h6F: begin e.we = 1; e.jmp = 1; v = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0}); e.imm = v; end
            7'h67: begin e.we = 1; e.jmp = 2; e.src = 1; v = $signed(w[31:20]); e.imm = v; end
            7'h37: begin e.we = 1; e.ir = 1; e.src = 1; e.a = 0; e.imm = {w[31:12], 12'h000}; end
            7'h17: begin e.we = 1; e.apc = 1; e.ir = 1; e.src = 1; e.imm = {w[31:12], 12'h000}; end
            default: legal = 0;  // includes W-ops at XLEN=32 and instr[1:0]!=11
        endcase
        if (!legal) begin e = '0; e.ill = 1; end
        else if (w == 32'h0000_0013) e = '0;
        if (e.d == 0) e.we = 0;
        e.pc = pc;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        chk("in_ready", in_ready, q.size() < 2);
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) begin
            e = q[0];
            chk("pc", out_pc, e.pc);
            chk("imm", out_immediate, e.imm);
            chk("we_reg", out_we_reg, e.we);
            chk("adder_pc", out_adder_pc, e.apc);
            chk("input_reg", out_input_reg, e.ir);
            chk("select_a", out_select_a, e.a);
            chk("select_b", out_select_b, e.b);
            chk("select_d", out_select_d, e.d);
            chk("source_alu", out_source_alu, e.src);
            chk("op_alu", out_op_code_alu, e.op);
            chk("mem_we", out_mem_we, e.mwe);
            chk("mem_size", out_mem_size, e.msz);
            chk("jmp_pc", out_jmp_pc, e.jmp);
            chk("b_pc", out_b_pc, e.bpc);
            chk("alu_not", out_alu_not, e.anot);
            chk("illegal", out_illegal, e.ill);
        end
    endtask

    // One clock: FIFO model updated from pre-edge occupancy, outputs checked at negedge
    task automatic tick();
        bit rdy, ov;
        rdy = q.size() < 2;
        ov  = q.size() > 0;
        @(posedge clk);
        if (reset || flush) q.delete();
        else begin
            if (ov && out_ready) void'(q.pop_front());
            if (in_valid && rdy) q.push_back(ref_decode(in_instr, in_pc));
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic offer(input logic [31:0] w, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = w;
        in_pc    = pc;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opcs [11];
        logic [31:0] r;
        int k;
        opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h3B, 7'h1B};
        r = $urandom;
        k = $urandom_range(0, 12);
        if (k == 11) return r;
        if (k == 12) return 32'h0000_0013;
        return {r[31:7], opcs[k]};
    endfunction

    initial begin
        // reset: empty, ready, outputs zero
        reset = 1'b1;
        tick();
        tick();
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_imm", out_immediate, 32'h0);
        chk("rst_we", out_we_reg, 1'b0);
        chk("rst_illegal", out_illegal, 1'b0);
        chk("rst_op", out_op_code_alu, 4'h0);
        reset = 1'b0;
        tick();

        // addi x1,x2,-1
        offer(32'hFFF1_0093, 32'h0000_0100);
        tick();
        in_valid = 1'b0;
        chk("addi_valid", out_valid, 1'b1);
        chk("addi_imm", out_immediate, 32'hFFFF_FFFF);
        chk("addi_sel_a", out_select_a, 5'd2);
        chk("addi_sel_d", out_select_d, 5'd1);
        chk("addi_op", out_op_code_alu, 4'b0000);
        chk("addi_src", out_source_alu, 1'b1);
        chk("addi_we", out_we_reg, 1'b1);
        chk("addi_ir", out_input_reg, 2'b01);
        tick();

        // beq x1,x2,-4
        offer(32'hFE20_8EE3, 32'h0000_0104);
        tick();
        in_valid = 1'b0;
        chk("beq_imm", out_immediate, 32'hFFFF_FFFC);
        chk("beq_op", out_op_code_alu, 4'b0001);
        chk("beq_not", out_alu_not, 1'b1);
        chk("beq_bpc", out_b_pc, 1'b1);
        chk("beq_we", out_we_reg, 1'b0);
        tick();

        // backpressure: three back-to-back offers with out_ready low
        out_ready = 1'b0;
        offer(32'h0030_8113, 32'h200);   // addi x2,x1,3
        tick();
        chk("bp_ready1", in_ready, 1'b1);
        offer(32'h4031_01B3, 32'h204);   // sub x3,x2,x3
        tick();
        chk("bp_ready2", in_ready, 1'b0);
        offer(32'h0001_2203, 32'h208);   // lw x4,0(x2)
        tick();
        chk("bp_hold_pc", out_pc, 32'h200);
        out_ready = 1'b1;
        tick();
        chk("bp_second_pc", out_pc, 32'h204);
        tick();
        chk("bp_third_pc", out_pc, 32'h208);
        in_valid = 1'b0;
        tick();
        chk("bp_drained", out_valid, 1'b0);

        // flush with both entries held and a live offer
        out_ready = 1'b0;
        offer(32'h0000_0537, 32'h300);   // lui x10,0
        tick();
        offer(32'h0000_0597, 32'h304);   // auipc x11,0
        tick();
        offer(32'h0080_006F, 32'h308);   // jal x0,8
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        tick();
        tick();

        // illegal words
        offer(32'h0000_0000, 32'h400);
        tick();
        in_valid = 1'b0;
        chk("ill0_illegal", out_illegal, 1'b1);
        chk("ill0_we", out_we_reg, 1'b0);
        chk("ill0_mwe", out_mem_we, 1'b0);
        chk("ill0_bpc", out_b_pc, 1'b0);
        offer(32'hFFFF_FFFF, 32'h404);
        tick();
        in_valid = 1'b0;
        chk("ill1_illegal", out_illegal, 1'b1);
        chk("ill1_we", out_we_reg, 1'b0);
        chk("ill1_pc", out_pc, 32'h404);
        tick();

        // reset mid-stream with skid full
        out_ready = 1'b0;
        offer(32'h00A5_8633, 32'h500);   // add x12,x11,x10
        tick();
        offer(32'h00C6_A023, 32'h504);   // sw x12,0(x13)
        tick();
        offer(32'h0000_8067, 32'h508);   // jalr x0,0(x1)
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        chk("rst2_valid", out_valid, 1'b0);
        chk("rst2_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        tick();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_instr  = rand_instr();
            in_pc     = {$urandom, 2'b00};
            tick();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
